// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, selectable standard or first-word-fall-through
// read, programmable almost flags, live fill count and sticky overflow/underflow flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 16,
  parameter int AF_LEVEL   = FIFO_SIZE - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0,
  parameter int PTR_WIDTH  = $clog2(FIFO_SIZE),
  parameter int CNT_WIDTH  = $clog2(FIFO_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [0:FIFO_SIZE-1];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  rd_acc;
  logic                  wr_acc;

  // Pointers wrap explicitly so any depth works, not only powers of two.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(FIFO_SIZE - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  always_comb begin
    rd_acc  = rd_en & ~empty;
    wr_acc  = wr_en & (~full | rd_acc);
    cnt_nxt = count;
    if (wr_acc && !rd_acc)
      cnt_nxt = count + CNT_WIDTH'(1);
    else if (rd_acc && !wr_acc)
      cnt_nxt = count - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc)
        rd_ptr <= ptr_inc(rd_ptr);
      count        <= cnt_nxt;
      full         <= (cnt_nxt == CNT_WIDTH'(FIFO_SIZE));
      almost_full  <= (cnt_nxt >= CNT_WIDTH'(AF_LEVEL));
      empty        <= (cnt_nxt == '0);
      almost_empty <= (cnt_nxt <= CNT_WIDTH'(AE_LEVEL));
      // A new error in the same cycle as a clear keeps the flag set.
      overflow     <= (wr_en & ~wr_acc) | (overflow & ~clr_err);
      underflow    <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          rdata <= '0;
        else if (rd_acc)
          rdata <= mem[rd_ptr];
      end
    end else begin : g_fwft
      assign rdata = mem[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: standard mode (depth 5), threshold flags (depth 16)
// and first-word-fall-through (depth 4), sharing one clock and reset.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // instance a: depth 5, standard read
  logic       a_wr = 0, a_rd = 0, a_clr = 0;
  logic [7:0] a_wdata = 0, a_rdata;
  logic       a_full, a_af, a_empty, a_ae, a_ovf, a_udf;
  logic [2:0] a_count;

  // instance b: depth 16, AF 14, AE 2
  logic       b_wr = 0, b_rd = 0, b_clr = 0;
  logic [7:0] b_wdata = 0, b_rdata;
  logic       b_full, b_af, b_empty, b_ae, b_ovf, b_udf;
  logic [4:0] b_count;

  // instance c: depth 4, first-word-fall-through
  logic       c_wr = 0, c_rd = 0, c_clr = 0;
  logic [7:0] c_wdata = 0, c_rdata;
  logic       c_full, c_af, c_empty, c_ae, c_ovf, c_udf;
  logic [2:0] c_count;

  sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_SIZE(5), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .wr_en(a_wr), .wdata(a_wdata), .rd_en(a_rd), .clr_err(a_clr),
    .rdata(a_rdata), .full(a_full), .almost_full(a_af), .empty(a_empty),
    .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_udf)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_SIZE(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(b_wr), .wdata(b_wdata), .rd_en(b_rd), .clr_err(b_clr),
    .rdata(b_rdata), .full(b_full), .almost_full(b_af), .empty(b_empty),
    .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_udf)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_SIZE(4), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .wr_en(c_wr), .wdata(c_wdata), .rd_en(c_rd), .clr_err(c_clr),
    .rdata(c_rdata), .full(c_full), .almost_full(c_af), .empty(c_empty),
    .almost_empty(c_ae), .count(c_count), .overflow(c_ovf), .underflow(c_udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    a_wr = w; a_wdata = d; a_rd = r; a_clr = c;
    tick();
    a_wr = 0; a_rd = 0; a_clr = 0;
  endtask

  task automatic c_cyc(input logic w, input logic [7:0] d, input logic r);
    c_wr = w; c_wdata = d; c_rd = r;
    tick();
    c_wr = 0; c_rd = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_ae", a_ae, 1);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_udf", a_udf, 0);
    chk("rst_rdata", a_rdata, 0);
    rst = 1'b1;

    // fill, drain, wrap
    for (int i = 1; i <= 5; i++) begin
      a_cyc(1, 8'(i), 0, 0);
      chk("fill_count", a_count, i);
    end
    chk("fill_full", a_full, 1);
    chk("fill_af", a_af, 1);
    chk("fill_ae", a_ae, 0);
    for (int i = 0; i < 3; i++) begin
      a_cyc(0, 0, 1, 0);
      chk("drain1_data", a_rdata, i + 1);
    end
    chk("drain1_count", a_count, 2);
    chk("drain1_ae", a_ae, 1);
    chk("drain1_af", a_af, 0);
    for (int i = 6; i <= 8; i++) a_cyc(1, 8'(i), 0, 0);
    chk("refill_count", a_count, 5);
    chk("refill_full", a_full, 1);
    for (int i = 0; i < 5; i++) begin
      a_cyc(0, 0, 1, 0);
      chk("drain2_data", a_rdata, i + 4);
    end
    chk("drain2_empty", a_empty, 1);
    chk("drain2_count", a_count, 0);

    // full with simultaneous read and write, then overflow
    for (int i = 0; i < 5; i++) a_cyc(1, 8'(8'h11 + i), 0, 0);
    a_cyc(1, 8'h55, 1, 0);
    chk("rw_full_data", a_rdata, 8'h11);
    chk("rw_full_count", a_count, 5);
    chk("rw_full_ovf", a_ovf, 0);
    a_cyc(1, 8'h99, 0, 0);
    chk("ovf_set", a_ovf, 1);
    chk("ovf_count", a_count, 5);
    for (int i = 0; i < 4; i++) begin
      a_cyc(0, 0, 1, 0);
      chk("ovf_drain", a_rdata, 8'h12 + i);
    end
    a_cyc(0, 0, 1, 0);
    chk("ovf_last", a_rdata, 8'h55);
    chk("ovf_empty", a_empty, 1);

    // error flags
    a_cyc(0, 0, 1, 0);
    chk("udf_set", a_udf, 1);
    chk("udf_rdata_hold", a_rdata, 8'h55);
    chk("udf_ovf_sticky", a_ovf, 1);
    a_cyc(0, 0, 1, 1);
    chk("udf_clr_race", a_udf, 1);
    chk("ovf_cleared", a_ovf, 0);
    a_cyc(0, 0, 0, 1);
    chk("clr_udf", a_udf, 0);
    chk("clr_ovf", a_ovf, 0);
    a_cyc(1, 8'h66, 1, 0);
    chk("udf_wr_count", a_count, 1);
    chk("udf_wr_flag", a_udf, 1);
    a_cyc(0, 0, 1, 1);
    chk("udf_wr_data", a_rdata, 8'h66);
    chk("udf_wr_clr", a_udf, 0);

    // reset mid-burst
    for (int i = 0; i < 3; i++) a_cyc(1, 8'(8'h70 + i), 0, 0);
    chk("mid_count", a_count, 3);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_empty", a_empty, 1);
    chk("mid_rst_ae", a_ae, 1);
    chk("mid_rst_rdata", a_rdata, 0);
    tick();
    rst = 1'b1;
    a_cyc(1, 8'hA1, 0, 0);
    chk("post_rst_count", a_count, 1);
    a_cyc(0, 0, 1, 0);
    chk("post_rst_data", a_rdata, 8'hA1);
    chk("post_rst_empty", a_empty, 1);

    // thresholds on depth 16
    chk("b_rst_ae", b_ae, 1);
    chk("b_rst_count", b_count, 0);
    for (int n = 1; n <= 16; n++) begin
      b_wr = 1; b_wdata = 8'(n);
      tick();
      b_wr = 0;
      chk("thr_count", b_count, n);
      chk("thr_ae", b_ae, (n <= 2) ? 1 : 0);
      chk("thr_af", b_af, (n >= 14) ? 1 : 0);
      chk("thr_full", b_full, (n == 16) ? 1 : 0);
    end
    b_rd = 1;
    tick();
    b_rd = 0;
    chk("thr_rdata", b_rdata, 1);
    chk("thr_full_drop", b_full, 0);

    // first-word-fall-through
    chk("c_rst_empty", c_empty, 1);
    c_cyc(1, 8'h3C, 0);
    chk("fwft_data", c_rdata, 8'h3C);
    chk("fwft_empty", c_empty, 0);
    chk("fwft_count", c_count, 1);
    c_cyc(1, 8'h4D, 1);
    chk("fwft_pop_data", c_rdata, 8'h4D);
    chk("fwft_pop_count", c_count, 1);
    c_cyc(0, 0, 1);
    chk("fwft_drained", c_empty, 1);
    for (int i = 0; i < 4; i++) c_cyc(1, 8'(8'hA0 + i), 0);
    chk("fwft_full", c_full, 1);
    chk("fwft_full_count", c_count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("fwft_wrap_data", c_rdata, 8'hA0 + i);
      c_cyc(0, 0, 1);
    end
    chk("fwft_end_empty", c_empty, 1);
    chk("fwft_udf_clear", c_udf, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
